hs_sync_receiver: RTL and testbench

- Terminates a self-timed Send/Ack pipeline chain, such as the conditional-elimination stage output, into a synchronous clock domain.
- Synchronizes the request, captures the bundled data word and returns a four-phase acknowledge.
- Buffers accepted packets in a small FIFO read by a synchronous consumer over valid/ready.
- Backpressure stops the upstream pipeline by withholding Ack_out.

---
 rtl/hs_rx_pkg.sv | 21 ++
 rtl/sync_ff.sv | 26 ++
 rtl/hs_sync_receiver.sv | 121 ++++++++++++
 tb/tb_hs_sync_receiver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_rx_pkg.sv
// Shared types and level constants for the Send/Ack receiver.
// Send_in and Ack_out are both active-low, so the named levels below keep the FSM readable.
package hs_rx_pkg;

   typedef enum logic [1:0] {
      RST_WAIT,
      IDLE,
      ACKED
   } state_e;

   localparam logic SEND_IDLE = 1'b1;
   localparam logic SEND_REQ  = 1'b0;
   localparam logic ACK_IDLE  = 1'b1;
   localparam logic ACK_ACT   = 1'b0;

   // Occupancy needs one bit more than the pointer so that "full" (== depth) is representable
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level.
// The reset value is a port so the owner decides which level is "safe" after reset.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rst_val_i,
   input  logic d_i,
   output logic q_o
);

   // Kept as a plain shift chain; the attribute stops tools from merging or retiming the stages
   (* dont_touch = "true" *) logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chain_q <= {STAGES{rst_val_i}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hs_sync_receiver.sv
// Terminates a self-timed four-phase Send/Ack chain into the CLK domain and buffers
// accepted words in a small FIFO drained over a valid/ready interface.
module hs_sync_receiver
   import hs_rx_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            CLK,
   input  logic                            MR,
   input  logic                            Send_in,
   input  logic [WIDTH-1:0]                Data_in,
   output logic                            Ack_out,
   output logic [WIDTH-1:0]                Dout,
   output logic                            Dout_valid,
   input  logic                            Dout_ready,
   output logic [count_width(DEPTH)-1:0]   Count
);

   localparam int CW = count_width(DEPTH);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic              sSend;
   state_e            state_q, state_d;
   logic              ack_q, ack_d;
   logic              push, pop;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   // Reset loads "request asserted" so a request still held low is never mistaken for idle
   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_send_sync (
      .clk_i     (CLK),
      .rst_i     (MR),
      .rst_val_i (SEND_REQ),
      .d_i       (Send_in),
      .q_o       (sSend)
   );

   always_ff @(posedge CLK) begin
      if (MR) begin
         state_q <= RST_WAIT;
         ack_q   <= ACK_IDLE;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   // Capture is gated on the registered count, so a same-cycle pop cannot open room for a push
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      push    = 1'b0;
      case (state_q)
         RST_WAIT: begin
            ack_d = ACK_IDLE;
            if (sSend == SEND_IDLE) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            ack_d = ACK_IDLE;
            if ((sSend == SEND_REQ) && (count_q < FULL_COUNT)) begin
               push    = 1'b1;
               ack_d   = ACK_ACT;
               state_d = ACKED;
            end
         end
         ACKED: begin
            if (sSend == SEND_IDLE) begin
               ack_d   = ACK_IDLE;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = ACK_IDLE;
            state_d = RST_WAIT;
         end
      endcase
   end

   assign pop = (count_q != '0) && Dout_ready;

   always_ff @(posedge CLK) begin
      if (MR) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; emptiness is tracked purely by the pointers and count
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= Data_in;
      end
   end

   assign Ack_out    = ack_q;
   assign Dout       = mem_q[rd_ptr_q];
   assign Dout_valid = (count_q != '0);
   assign Count      = count_q;

endmodule

// File: tb/tb_hs_sync_receiver.sv
// Bench for hs_sync_receiver: directed protocol scenarios with literal expectations, then
// randomized upstream/consumer traffic, all shadowed by a cycle-level behavioural model.
module tb_hs_sync_receiver;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int SS    = 2;

   logic                   CLK;
   logic                   MR;
   logic                   Send_in;
   logic [WIDTH-1:0]       Data_in;
   logic                   Ack_out;
   logic [WIDTH-1:0]       Dout;
   logic                   Dout_valid;
   logic                   Dout_ready;
   logic [$clog2(DEPTH):0] Count;

   int checks = 0;
   int errors = 0;

   // Model state: a delay line standing in for the synchronizer, two protocol flags and a queue
   logic             modelValid = 1'b0;
   logic             hist [SS];
   logic             mWaitIdle;
   logic             mAcked;
   logic             mAck;
   logic [WIDTH-1:0] mq [$];

   hs_sync_receiver #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SS)
   ) dut (
      .CLK        (CLK),
      .MR         (MR),
      .Send_in    (Send_in),
      .Data_in    (Data_in),
      .Ack_out    (Ack_out),
      .Dout       (Dout),
      .Dout_valid (Dout_valid),
      .Dout_ready (Dout_ready),
      .Count      (Count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic send, input logic [WIDTH-1:0] data, input logic ready);
      Send_in    = send;
      Data_in    = data;
      Dout_ready = ready;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic waitAck(input logic lvl, input int maxCyc, input string name);
      int n = 0;
      while (Ack_out !== lvl && n < maxCyc) begin
         step();
         n++;
      end
      checkOutput(name, {31'b0, Ack_out}, {31'b0, lvl});
   endtask

   task automatic sendPacket(input logic [WIDTH-1:0] data);
      applyStimulus(1'b0, data, 1'b0);
      waitAck(1'b0, 20, "send_ack_fall");
      applyStimulus(1'b1, data, 1'b0);
      waitAck(1'b1, 20, "send_ack_rise");
   endtask

   task automatic popOne(input logic [WIDTH-1:0] expected);
      checkOutput("pop_valid", {31'b0, Dout_valid}, 32'd1);
      checkOutput("pop_data", Dout, expected);
      applyStimulus(Send_in, Data_in, 1'b1);
      step();
      applyStimulus(Send_in, Data_in, 1'b0);
   endtask

   // Model: one push per four-phase request, seen SS edges late, only while not full
   always @(posedge CLK) begin
      logic s;
      logic doPop;
      logic doPush;
      if (MR) begin
         for (int i = 0; i < SS; i++) hist[i] = 1'b0;
         mWaitIdle  = 1'b1;
         mAcked     = 1'b0;
         mAck       = 1'b1;
         mq.delete();
         modelValid = 1'b1;
      end else if (modelValid) begin
         s = hist[SS-1];
         for (int i = SS-1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = Send_in;
         doPop  = (mq.size() > 0) && Dout_ready;
         doPush = !mWaitIdle && !mAcked && (s == 1'b0) && (mq.size() < DEPTH);
         if (mWaitIdle) begin
            if (s) mWaitIdle = 1'b0;
         end else if (mAcked) begin
            if (s) mAcked = 1'b0;
         end else if (doPush) begin
            mAcked = 1'b1;
         end
         if (doPop) void'(mq.pop_front());
         if (doPush) mq.push_back(Data_in);
         mAck = !mAcked;
      end
   end

   always @(negedge CLK) begin
      if (modelValid) begin
         checkOutput("model_ack", {31'b0, Ack_out}, {31'b0, mAck});
         checkOutput("model_valid", {31'b0, Dout_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
         checkOutput("model_count", {29'b0, Count}, mq.size());
         if (mq.size() != 0) checkOutput("model_dout", Dout, mq[0]);
      end
   end

   initial begin
      int head;
      int gap;
      applyStimulus(1'b1, '0, 1'b0);
      MR = 1'b1;
      step();
      step();
      checkOutput("rst_ack", {31'b0, Ack_out}, 32'd1);
      checkOutput("rst_valid", {31'b0, Dout_valid}, 32'd0);
      checkOutput("rst_count", {29'b0, Count}, 32'd0);
      MR = 1'b0;
      repeat (4) step();

      // Single packet with exact edge latencies
      applyStimulus(1'b0, 32'hA5A5_0001, 1'b0);
      step();
      step();
      checkOutput("single_ack_e2", {31'b0, Ack_out}, 32'd1);
      step();
      checkOutput("single_ack_e3", {31'b0, Ack_out}, 32'd0);
      checkOutput("single_valid", {31'b0, Dout_valid}, 32'd1);
      checkOutput("single_dout", Dout, 32'hA5A5_0001);
      checkOutput("single_count", {29'b0, Count}, 32'd1);
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b0);
      step();
      step();
      checkOutput("single_rel_e2", {31'b0, Ack_out}, 32'd0);
      step();
      checkOutput("single_rel_e3", {31'b0, Ack_out}, 32'd1);
      popOne(32'hA5A5_0001);
      checkOutput("single_empty", {29'b0, Count}, 32'd0);

      // Fill and backpressure
      for (int i = 1; i <= 4; i++) sendPacket(i);
      checkOutput("fill_count", {29'b0, Count}, 32'd4);
      applyStimulus(1'b0, 32'd5, 1'b0);
      repeat (10) step();
      checkOutput("full_noack", {31'b0, Ack_out}, 32'd1);
      checkOutput("full_count", {29'b0, Count}, 32'd4);
      popOne(32'd1);
      checkOutput("full_after_pop", {29'b0, Count}, 32'd3);
      waitAck(1'b0, 5, "full_late_ack");
      checkOutput("full_refill", {29'b0, Count}, 32'd4);
      applyStimulus(1'b1, 32'd5, 1'b0);
      waitAck(1'b1, 20, "full_release");
      for (int i = 2; i <= 5; i++) popOne(i);
      checkOutput("fill_drained", {29'b0, Count}, 32'd0);

      // Capture edge coincides with a pop at Count == 2, across pointer wrap
      sendPacket(32'd1);
      sendPacket(32'd2);
      head = 1;
      for (int p = 3; p <= 10; p++) begin
         applyStimulus(1'b0, p, 1'b0);
         step();
         step();
         checkOutput("sim_head", Dout, head);
         applyStimulus(1'b0, p, 1'b1);
         step();
         head++;
         applyStimulus(1'b0, p, 1'b0);
         checkOutput("sim_count", {29'b0, Count}, 32'd2);
         checkOutput("sim_ack", {31'b0, Ack_out}, 32'd0);
         applyStimulus(1'b1, p, 1'b0);
         waitAck(1'b1, 20, "sim_release");
      end
      popOne(32'd9);
      popOne(32'd10);

      // Reset while ACKED with the request still held low
      applyStimulus(1'b0, 32'h55, 1'b0);
      waitAck(1'b0, 20, "rstmid_ack_fall");
      MR = 1'b1;
      step();
      MR = 1'b0;
      checkOutput("rstmid_ack", {31'b0, Ack_out}, 32'd1);
      checkOutput("rstmid_count", {29'b0, Count}, 32'd0);
      repeat (6) step();
      checkOutput("rstmid_nocap_count", {29'b0, Count}, 32'd0);
      checkOutput("rstmid_nocap_ack", {31'b0, Ack_out}, 32'd1);
      checkOutput("rstmid_nocap_valid", {31'b0, Dout_valid}, 32'd0);
      applyStimulus(1'b1, 32'h55, 1'b0);
      repeat (4) step();
      sendPacket(32'h77);
      checkOutput("rstmid_one_entry", {29'b0, Count}, 32'd1);
      popOne(32'h77);

      // Long request hold yields a single write
      applyStimulus(1'b0, 32'h99, 1'b0);
      waitAck(1'b0, 20, "hold_ack_fall");
      repeat (20) step();
      checkOutput("hold_ack_low", {31'b0, Ack_out}, 32'd0);
      checkOutput("hold_count", {29'b0, Count}, 32'd1);
      applyStimulus(1'b1, 32'h99, 1'b0);
      waitAck(1'b1, 20, "hold_release");
      checkOutput("hold_count_after", {29'b0, Count}, 32'd1);
      popOne(32'h99);

      // Pop on empty is ignored
      applyStimulus(1'b1, '0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("empty_count", {29'b0, Count}, 32'd0);
         checkOutput("empty_valid", {31'b0, Dout_valid}, 32'd0);
      end
      applyStimulus(1'b1, '0, 1'b0);
      sendPacket(32'hBEEF);
      popOne(32'hBEEF);

      // Randomized traffic; the model checks every cycle
      gap = 2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            MR = 1'b1;
            Send_in = 1'b1;
            step();
            MR = 1'b0;
            gap = 4;
         end
         if (Send_in == 1'b1 && Ack_out == 1'b1) begin
            if (gap == 0) begin
               Send_in = 1'b0;
               Data_in = $urandom;
               gap = $urandom_range(0, 3);
            end else begin
               gap--;
            end
         end else if (Send_in == 1'b0 && Ack_out == 1'b0) begin
            Send_in = 1'b1;
         end
         if (c < 1500) Dout_ready = ($urandom_range(0, 3) == 0);
         else          Dout_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      applyStimulus(1'b1, Data_in, 1'b1);
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
